mdu_issue_ctrl: RTL

//  Initiator side of the MDU valid/ready interface. Sits between decode/execute and mdu_top.

---
 rtl/mdu_issue_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_issue_ctrl : issues one M-extension op to the MDU and returns a tagged,
//                  held writeback; div-by-zero and signed overflow answered locally
// Revision       : 1.0  initial release
// ----------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int WIDTH      = 32,
  parameter int P_DATA_MSB = WIDTH - 1,
  parameter int P_TIMEOUT  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_op,
  input  logic [P_DATA_MSB:0]   i_req_rs1,
  input  logic [P_DATA_MSB:0]   i_req_rs2,
  input  logic [4:0]            i_req_rd_addr,
  output logic                  o_mdu_valid,
  output logic [2:0]            o_mdu_op,
  output logic [P_DATA_MSB:0]   o_mdu_rs1,
  output logic [P_DATA_MSB:0]   o_mdu_rs2,
  input  logic                  i_mdu_ready,
  input  logic [P_DATA_MSB:0]   i_mdu_rd,
  output logic                  o_wb_valid,
  input  logic                  i_wb_ready,
  output logic [4:0]            o_wb_addr,
  output logic [P_DATA_MSB:0]   o_wb_data,
  output logic                  o_wb_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_DIV  = 3'b100;
  localparam logic [2:0] c_OP_DIVU = 3'b101;
  localparam logic [2:0] c_OP_REM  = 3'b110;
  localparam logic [2:0] c_OP_REMU = 3'b111;

  localparam int                  c_CNT_W   = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0]  c_TO_LAST = c_CNT_W'(P_TIMEOUT - 1);
  localparam logic [P_DATA_MSB:0] c_MIN     = {1'b1, {P_DATA_MSB{1'b0}}};

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                w_rs2_zero;
  logic                w_ovf;
  logic                w_fast;
  logic [P_DATA_MSB:0] w_fast_res;

  assign w_rs2_zero = (i_req_rs2 == '0);
  assign w_ovf      = (i_req_rs1 == c_MIN) && (i_req_rs2 == '1);

  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    case (i_req_op)
      c_OP_DIV, c_OP_DIVU: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_res = '1;
        end else if (i_req_op == c_OP_DIV && w_ovf) begin
          w_fast     = 1'b1;
          w_fast_res = i_req_rs1;
        end
      end
      c_OP_REM, c_OP_REMU: begin
        if (w_rs2_zero) begin
          w_fast     = 1'b1;
          w_fast_res = i_req_rs1;
        end else if (i_req_op == c_OP_REM && w_ovf) begin
          w_fast     = 1'b1;
          w_fast_res = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      o_req_ready <= 1'b1;
      o_mdu_valid <= 1'b0;
      o_mdu_op    <= '0;
      o_mdu_rs1   <= '0;
      o_mdu_rs2   <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_wb_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            o_wb_addr   <= i_req_rd_addr;
            o_wb_err    <= 1'b0;
            if (w_fast) begin
              o_wb_data  <= w_fast_res;
              o_wb_valid <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              o_mdu_valid <= 1'b1;
              o_mdu_op    <= i_req_op;
              o_mdu_rs1   <= i_req_rs1;
              o_mdu_rs2   <= i_req_rs2;
              r_cnt       <= '0;
              r_state     <= S_ISSUE;
            end
          end
        end
        // A ready still high from the previous op must not complete this one.
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        // r_cnt holds the number of WAIT cycles already spent without ready.
        S_WAIT: begin
          if (i_mdu_ready) begin
            o_wb_data   <= i_mdu_rd;
            o_mdu_valid <= 1'b0;
            o_wb_valid  <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == c_TO_LAST) begin
            o_wb_data   <= '0;
            o_wb_err    <= 1'b1;
            o_mdu_valid <= 1'b0;
            o_wb_valid  <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RESP: begin
          if (i_wb_ready) begin
            o_wb_valid  <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
